panda_risc_v_itcm_ctrler: RTL and testbench
===========================================

Name: panda_risc_v_itcm_ctrler

Overview:
- ICB slave (responder) that terminates the instruction ICB master and serves it from a single-port, 1-cycle-latency ITCM SRAM.
- Also accepts writes so the loader and debug can fill the ITCM.
- Does the address range and alignment checks, and buffers responses in a 2-entry FIFO so master-side rsp backpressure never corrupts SRAM read data.
- Responses return in command order with 1-cycle minimum latency.

Parameters:
- ITCM_BASE, 32'h0000_0000, byte base address of the ITCM window.
- ITCM_DEPTH, 4096, ITCM depth in 32-bit words; power of 2, 2..65536.
- simulation_delay, 1, register update delay for simulation only.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_icb_cmd_addr  in  32  byte address
- s_icb_cmd_read  in  1  1 = read, 0 = write
- s_icb_cmd_wdata  in  32  write data
- s_icb_cmd_wmask  in  4  byte write enables
- s_icb_cmd_valid  in  1  command valid
- s_icb_cmd_ready  out  1  command ready
- s_icb_rsp_rdata  out  32  read data
- s_icb_rsp_err  out  1  access error
- s_icb_rsp_valid  out  1  response valid
- s_icb_rsp_ready  in  1  response ready
- itcm_en  out  1  SRAM enable
- itcm_wen  out  4  SRAM byte write enables
- itcm_addr  out  16  SRAM word address; upper bits 0 when ITCM_DEPTH < 65536
- itcm_din  out  32  SRAM write data
- itcm_dout  in  32  SRAM read data, valid the cycle after an en=1 read

Behaviour:
- Interface clocking and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values: s_icb_cmd_ready=0 while in reset, s_icb_rsp_valid=0, rdata=0, err=0, itcm_en=0, itcm_wen=0.
- On reset: stage s1 and the FIFO are cleared; in-flight commands are dropped with no response.
- Command handshake: cmd_valid & cmd_ready.
- Occupancy: occ = s1_vld + fifo_cnt.
- cmd_ready = (occ <= 1). It is a function of registers only, with no combinational path from rsp_ready.
- Error check, combinational on the handshaking command: err = (addr[1:0] != 0) | (addr < ITCM_BASE) | (addr >= ITCM_BASE + 4*ITCM_DEPTH). The range is computed in 33-bit arithmetic so no wrap occurs at 32'hFFFF_FFFC.
- SRAM drive, only when handshaking and !err:
  - itcm_en=1
  - itcm_addr = (addr - ITCM_BASE) >> 2
  - itcm_wen = read ? 4'b0000 : wmask
  - itcm_din = wdata
- Otherwise itcm_en=0 and itcm_wen=0. Errored commands never touch the SRAM.
- A write with wmask=0 is legal: en=1, wen=0, and it returns ok.
- Stage s1 captures {vld, err, read} at the handshake edge.
- In the next cycle the s1 payload is:
  - rdata = (read & !err) ? itcm_dout : 32'h0
  - err as captured
- Response selection:
  - FIFO non-empty: rsp presents the FIFO head.
  - FIFO empty and s1_vld: rsp presents the s1 payload (bypass), giving 1-cycle latency.
- End of every cycle with s1_vld: if s1 was not consumed by the bypass (FIFO non-empty, or rsp_ready=0), its payload is pushed into the FIFO. This captures itcm_dout in the only cycle it is valid.
- Simultaneous push and pop of the FIFO is allowed; fifo_cnt is unchanged.
- FIFO: depth 2, circular read/write pointers with wrap. Overflow is impossible given the cmd_ready rule.
- Ordering is strict FIFO; the FIFO head always has priority over s1.
- Back-to-back reads at full rate while rsp_ready=1 give 1 response per cycle.
- rsp_valid=1 must hold stable with unchanged payload until the rsp handshake.

Test Plan:
- Preload SRAM word 5 = 32'hDEAD_BEEF. Read addr 32'h14 with rsp_ready=1 → rsp_valid next cycle, rdata=32'hDEAD_BEEF, err=0.
- Write addr 32'h8, wdata=32'h1122_3344, wmask=4'b0101 over old value 32'hAABB_CCDD → rsp err=0, rdata=0. A following read of 32'h8 returns 32'hAA22_CC44.
- Read addr 32'h6 (misaligned), and read addr 32'h4000 with ITCM_DEPTH=4096 → both rsp err=1, rdata=0, itcm_en never asserted.
- Hold rsp_ready=0 and issue reads to words 0,1,2 → cmd_ready drops after 2 accepts, the third stalls. Release rsp_ready → responses return in order with correct data; the third read is then accepted and completes.
- 8 back-to-back reads with rsp_ready=1 → 8 consecutive rsp cycles, cmd_ready constantly 1.
- Assert resetn=0 while 2 responses are pending → rsp_valid=0 immediately. After release, cmd_ready=1 and no stale responses appear.

Source files
------------

// File: rtl/panda_risc_v_itcm_ctrler.sv
`default_nettype none
// ============================================================================
// Module  : panda_risc_v_itcm_ctrler
// Brief   : ICB slave serving instruction/loader traffic from a 1-cycle ITCM,
//           with range/alignment checks and a 2-entry response FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module panda_risc_v_itcm_ctrler #(
    parameter logic [31:0] ITCM_BASE        = 32'h0000_0000,
    parameter int          ITCM_DEPTH       = 4096,
    parameter int          simulation_delay = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic [31:0] s_icb_cmd_addr,
    input  logic        s_icb_cmd_read,
    input  logic [31:0] s_icb_cmd_wdata,
    input  logic [3:0]  s_icb_cmd_wmask,
    input  logic        s_icb_cmd_valid,
    output logic        s_icb_cmd_ready,

    output logic [31:0] s_icb_rsp_rdata,
    output logic        s_icb_rsp_err,
    output logic        s_icb_rsp_valid,
    input  logic        s_icb_rsp_ready,

    output logic        itcm_en,
    output logic [3:0]  itcm_wen,
    output logic [15:0] itcm_addr,
    output logic [31:0] itcm_din,
    input  logic [31:0] itcm_dout
);

    localparam int          AW    = (ITCM_DEPTH > 1) ? $clog2(ITCM_DEPTH) : 1;
    localparam logic [32:0] LIMIT = {1'b0, ITCM_BASE} + (33'(ITCM_DEPTH) * 33'd4);

    // Register-only ready: held low until the first clock after reset release.
    logic        rdy_en_q;

    logic        s1_vld_q, s1_vld_d;
    logic        s1_err_q, s1_err_d;
    logic        s1_read_q, s1_read_d;

    logic [31:0] fifo_data_q [2];
    logic        fifo_err_q  [2];
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [1:0]  w_occ;
    logic        w_cmd_hs;
    logic        w_err;
    logic [31:0] w_off;
    logic        w_fifo_empty;
    logic [31:0] w_s1_rdata;
    logic        w_push;
    logic        w_pop;

    logic        unused_sim_delay;
    logic [15:0] unused_off;

    assign unused_sim_delay = (simulation_delay != 0);
    assign unused_off       = 16'({w_off[31:AW+2], w_off[1:0]});

    assign w_occ           = {1'b0, s1_vld_q} + cnt_q;
    assign s_icb_cmd_ready = rdy_en_q & (w_occ <= 2'd1);
    assign w_cmd_hs        = s_icb_cmd_valid & s_icb_cmd_ready;

    // 33-bit compare so a window ending at the top of the address map cannot wrap.
    assign w_err = (s_icb_cmd_addr[1:0] != 2'b00)
                 | ({1'b0, s_icb_cmd_addr} <  {1'b0, ITCM_BASE})
                 | ({1'b0, s_icb_cmd_addr} >= LIMIT);

    assign w_off     = s_icb_cmd_addr - ITCM_BASE;
    assign itcm_addr = 16'(w_off[AW+1:2]);
    assign itcm_din  = s_icb_cmd_wdata;
    assign itcm_en   = w_cmd_hs & ~w_err;
    assign itcm_wen  = (w_cmd_hs & ~w_err & ~s_icb_cmd_read) ? s_icb_cmd_wmask : 4'b0000;

    assign s1_vld_d  = w_cmd_hs;
    assign s1_err_d  = w_cmd_hs & w_err;
    assign s1_read_d = w_cmd_hs & s_icb_cmd_read;

    assign w_s1_rdata   = (s1_read_q & ~s1_err_q) ? itcm_dout : 32'h0;
    assign w_fifo_empty = (cnt_q == 2'd0);

    assign s_icb_rsp_valid = ~w_fifo_empty | s1_vld_q;
    assign s_icb_rsp_rdata = w_fifo_empty ? w_s1_rdata : fifo_data_q[rptr_q];
    assign s_icb_rsp_err   = w_fifo_empty ? s1_err_q   : fifo_err_q[rptr_q];

    // SRAM data is only valid this cycle, so park it unless the bypass takes it.
    assign w_push = s1_vld_q & ~(w_fifo_empty & s_icb_rsp_ready);
    assign w_pop  = ~w_fifo_empty & s_icb_rsp_ready;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (w_push) begin
            wptr_d = ~wptr_q;
        end
        if (w_pop) begin
            rptr_d = ~rptr_q;
        end
        if (w_push && !w_pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (w_pop && !w_push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_en_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_read_q <= 1'b0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            rdy_en_q  <= 1'b1;
            s1_vld_q  <= s1_vld_d;
            s1_err_q  <= s1_err_d;
            s1_read_q <= s1_read_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_data_q[0] <= 32'h0;
            fifo_data_q[1] <= 32'h0;
            fifo_err_q[0]  <= 1'b0;
            fifo_err_q[1]  <= 1'b0;
        end else if (w_push) begin
            fifo_data_q[wptr_q] <= w_s1_rdata;
            fifo_err_q[wptr_q]  <= s1_err_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_panda_risc_v_itcm_ctrler.sv
`default_nettype none
// ============================================================================
// Module  : tb_panda_risc_v_itcm_ctrler
// Brief   : directed bench with SRAM model and in-order response scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_panda_risc_v_itcm_ctrler;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] s_icb_cmd_addr = '0;
    logic        s_icb_cmd_read = 1'b0;
    logic [31:0] s_icb_cmd_wdata = '0;
    logic [3:0]  s_icb_cmd_wmask = '0;
    logic        s_icb_cmd_valid = 1'b0;
    logic        s_icb_cmd_ready;
    logic [31:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        s_icb_rsp_valid;
    logic        s_icb_rsp_ready = 1'b1;
    logic        itcm_en;
    logic [3:0]  itcm_wen;
    logic [15:0] itcm_addr;
    logic [31:0] itcm_din;
    logic [31:0] itcm_dout = '0;

    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] sram [4096];

    logic [31:0] ref_mem [16];
    logic [32:0] sb [$];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    logic        acc = 1'b0;

    always #5 clk = ~clk;

    panda_risc_v_itcm_ctrler #(
        .ITCM_BASE(32'h0000_0000),
        .ITCM_DEPTH(4096),
        .simulation_delay(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .s_icb_cmd_addr(s_icb_cmd_addr),
        .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata),
        .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_cmd_valid(s_icb_cmd_valid),
        .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_rsp_rdata(s_icb_rsp_rdata),
        .s_icb_rsp_err(s_icb_rsp_err),
        .s_icb_rsp_valid(s_icb_rsp_valid),
        .s_icb_rsp_ready(s_icb_rsp_ready),
        .itcm_en(itcm_en),
        .itcm_wen(itcm_wen),
        .itcm_addr(itcm_addr),
        .itcm_din(itcm_din),
        .itcm_dout(itcm_dout)
    );

    // Single-port SRAM, read data one cycle after an enabled non-write access.
    always @(posedge clk) begin
        if (pre_we) begin
            sram[pre_addr] <= pre_data;
        end else if (itcm_en) begin
            for (int b = 0; b < 4; b++) begin
                if (itcm_wen[b]) sram[itcm_addr[11:0]][8*b +: 8] <= itcm_din[8*b +: 8];
            end
            if (itcm_wen == 4'b0000) itcm_dout <= sram[itcm_addr[11:0]];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge, then return just after the next rising edge.
    task automatic step();
        logic        e_err;
        logic [31:0] e_data;
        logic [31:0] a;
        @(negedge clk);
        acc = 1'b0;
        if (resetn && s_icb_cmd_valid && s_icb_cmd_ready) begin
            acc   = 1'b1;
            a     = s_icb_cmd_addr;
            e_err = (a[1:0] != 2'b00) || (a >= 32'h0000_4000);
            e_data = 32'h0;
            if (!e_err) begin
                check("itcm_en_ok", {63'h0, itcm_en}, 64'h1);
                check("itcm_addr", {48'h0, itcm_addr}, {52'h0, a[13:2]});
                check("itcm_wen", {60'h0, itcm_wen},
                      {60'h0, (s_icb_cmd_read ? 4'b0000 : s_icb_cmd_wmask)});
                if (s_icb_cmd_read) begin
                    e_data = ref_mem[a[5:2]];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_icb_cmd_wmask[b]) ref_mem[a[5:2]][8*b +: 8] = s_icb_cmd_wdata[8*b +: 8];
                    end
                end
            end else begin
                check("itcm_en_err", {63'h0, itcm_en}, 64'h0);
            end
            sb.push_back({e_err, e_data});
        end else begin
            check("itcm_en_idle", {60'h0, itcm_wen, itcm_en}, 64'h0);
        end
        if (s_icb_rsp_valid && s_icb_rsp_ready) begin
            pops++;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'h1, 64'h0);
            end else begin
                check("rsp", {31'h0, s_icb_rsp_err, s_icb_rsp_rdata}, {31'h0, sb.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                         input logic [3:0] wm);
        s_icb_cmd_addr  = a;
        s_icb_cmd_read  = rd;
        s_icb_cmd_wdata = wd;
        s_icb_cmd_wmask = wm;
        s_icb_cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc) break;
        end
        check("accept", {63'h0, acc}, 64'h1);
        s_icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
        end
        ref_mem[2] = 32'hAABB_CCDD;
        ref_mem[5] = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            pre_we   = 1'b1;
            pre_addr = 12'(i);
            pre_data = ref_mem[i];
        end
        @(posedge clk);
        #1;
        pre_we = 1'b0;

        // Reset values
        check("rst_cmd_ready", {63'h0, s_icb_cmd_ready}, 64'h0);
        check("rst_rsp_valid", {63'h0, s_icb_rsp_valid}, 64'h0);
        check("rst_rsp", {31'h0, s_icb_rsp_err, s_icb_rsp_rdata}, 64'h0);
        check("rst_itcm", {59'h0, itcm_wen, itcm_en}, 64'h0);

        resetn = 1'b1;
        step();
        check("cmd_ready_post_rst", {63'h0, s_icb_cmd_ready}, 64'h1);

        // Single read, 1-cycle latency
        issue(32'h14, 1'b1, 32'h0, 4'h0);
        p0 = pops;
        step();
        check("read_latency", 64'(pops - p0), 64'h1);
        drain();

        // Partial write then readback
        issue(32'h8, 1'b0, 32'h1122_3344, 4'b0101);
        drain();
        issue(32'h8, 1'b1, 32'h0, 4'h0);
        drain();
        check("merged_word", {32'h0, ref_mem[2]}, 64'hAA22_CC44);

        // Zero-mask write is a legal no-op
        issue(32'hC, 1'b0, 32'hFFFF_FFFF, 4'b0000);
        issue(32'hC, 1'b1, 32'h0, 4'h0);
        drain();

        // Misaligned and out-of-range accesses
        issue(32'h6, 1'b1, 32'h0, 4'h0);
        issue(32'h4000, 1'b1, 32'h0, 4'h0);
        issue(32'hFFFF_FFFC, 1'b0, 32'h5555_5555, 4'hF);
        drain();

        // Backpressure: third command stalls until responses drain
        s_icb_rsp_ready = 1'b0;
        issue(32'h0, 1'b1, 32'h0, 4'h0);
        issue(32'h4, 1'b1, 32'h0, 4'h0);
        s_icb_cmd_addr  = 32'h8;
        s_icb_cmd_read  = 1'b1;
        s_icb_cmd_valid = 1'b1;
        step();
        check("stall_acc0", {63'h0, acc}, 64'h0);
        check("stall_ready", {63'h0, s_icb_cmd_ready}, 64'h0);
        step();
        check("stall_acc1", {63'h0, acc}, 64'h0);
        check("stall_held_valid", {63'h0, s_icb_rsp_valid}, 64'h1);
        s_icb_rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc) break;
        end
        check("stall_release_acc", {63'h0, acc}, 64'h1);
        s_icb_cmd_valid = 1'b0;
        drain();

        // Full-rate reads
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            s_icb_cmd_addr  = 32'(i) * 32'd4;
            s_icb_cmd_read  = 1'b1;
            s_icb_cmd_valid = 1'b1;
            step();
            check("b2b_acc", {63'h0, acc}, 64'h1);
        end
        s_icb_cmd_valid = 1'b0;
        check("b2b_pops_inflight", 64'(pops - p0), 64'h7);
        step();
        check("b2b_pops", 64'(pops - p0), 64'h8);
        drain();

        // Reset with two responses pending
        s_icb_rsp_ready = 1'b0;
        issue(32'h10, 1'b1, 32'h0, 4'h0);
        issue(32'h14, 1'b1, 32'h0, 4'h0);
        step();
        resetn = 1'b0;
        #1;
        check("async_rst_valid", {63'h0, s_icb_rsp_valid}, 64'h0);
        check("async_rst_ready", {63'h0, s_icb_cmd_ready}, 64'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        s_icb_rsp_ready = 1'b1;
        step();
        check("rerst_ready", {63'h0, s_icb_cmd_ready}, 64'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_stale_rsp", {63'h0, s_icb_rsp_valid}, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
